// File: rtl/codec_cfg_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer_if
//  Description : Bus bundle between the codec configuration sequencer, its
//                table ROM/BRAM and the I2C master core.
//                  rom_addr   - table read address (sequencer -> ROM)
//                  rom_data   - {reg_addr[15:0], data[7:0]}, 1 cycle latency
//                  xfer_valid - write request to I2C master
//                  xfer_ready - I2C master accepts request on valid&ready
//                  xfer_dev   - 7-bit I2C device address
//                  xfer_data  - reg_hi, reg_lo, data (MSB first)
//                  xfer_done  - 1-cycle pulse, transaction finished
//                  xfer_nack  - qualified by xfer_done, 1 = NACK seen
//                Modport master = sequencer side, slave = ROM / I2C side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface codec_cfg_sequencer_if #(
    parameter int TABLE_AW = 6
);
    logic [TABLE_AW-1:0] rom_addr;
    logic [23:0]         rom_data;
    logic                xfer_valid;
    logic                xfer_ready;
    logic [6:0]          xfer_dev;
    logic [23:0]         xfer_data;
    logic                xfer_done;
    logic                xfer_nack;

    modport master (
        output rom_addr,
        input  rom_data,
        output xfer_valid,
        input  xfer_ready,
        output xfer_dev,
        output xfer_data,
        input  xfer_done,
        input  xfer_nack
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  xfer_valid,
        output xfer_ready,
        input  xfer_dev,
        input  xfer_data,
        output xfer_done,
        output xfer_nack
    );
endinterface
`default_nettype wire

// File: rtl/codec_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer
//  Description : Boot-time codec configuration controller. Walks a register
//                write table and issues each entry as a 3-byte I2C write,
//                with timed delay entries and per-entry NACK retry.
//  Ports       : clk, rst_n (synchronous, active low), start (rerun pulse),
//                bus (codec_cfg_sequencer_if.master: ROM + I2C master),
//                busy, done (sticky), error (sticky), err_index.
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR    = 7'h3B,
    parameter int         TABLE_AW    = 6,
    parameter int         TICK_CYCLES = 98304,
    parameter int         MAX_RETRY   = 3,
    parameter bit         AUTO_START  = 1'b1
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    codec_cfg_sequencer_if.master     bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [TABLE_AW-1:0]       err_index
);
    localparam int c_TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);
    localparam logic [TABLE_AW-1:0]  c_IDX_LAST  = {TABLE_AW{1'b1}};
    localparam logic [15:0]          c_REG_DELAY = 16'hFFFE;
    localparam logic [23:0]          c_ENTRY_END = 24'hFFFFFF;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_ISSUE  = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;
    localparam logic [2:0] c_ST_DELAY  = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;
    localparam logic [2:0] c_ST_ERROR  = 3'd7;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [TABLE_AW-1:0]  r_idx;
    logic [c_RETRY_W-1:0] r_retry;
    logic [7:0]           r_count;
    logic [c_TICK_W-1:0]  r_tick;
    logic [23:0]          r_xfer_data;
    logic                 r_done;
    logic                 r_error;
    logic [TABLE_AW-1:0]  r_err_index;
    logic                 r_boot;

    logic w_is_end;
    logic w_is_delay;
    logic w_last;
    logic w_delay_fin;

    assign w_is_end   = (bus.rom_data == c_ENTRY_END);
    assign w_is_delay = (bus.rom_data[23:8] == c_REG_DELAY);
    // Last table slot: a completed entry here overruns the table.
    assign w_last     = (r_idx == c_IDX_LAST);
    // Finish either on an already-zero count, or on the final tick of the
    // last millisecond, so N ms costs exactly N*TICK_CYCLES cycles.
    assign w_delay_fin = (r_count == 8'd0) ||
                         ((r_count == 8'd1) && (r_tick == c_TICK_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start || (AUTO_START && r_boot)) begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_next = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (w_is_end) begin
                    w_next = c_ST_DONE;
                end else if (w_is_delay) begin
                    w_next = c_ST_DELAY;
                end else begin
                    w_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (bus.xfer_ready) begin
                    w_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (bus.xfer_done) begin
                    if (!bus.xfer_nack) begin
                        w_next = w_last ? c_ST_ERROR : c_ST_FETCH;
                    end else if (r_retry == c_RETRY_MAX) begin
                        w_next = c_ST_ERROR;
                    end else begin
                        w_next = c_ST_ISSUE;
                    end
                end
            end
            c_ST_DELAY: begin
                if (w_delay_fin) begin
                    w_next = w_last ? c_ST_ERROR : c_ST_FETCH;
                end
            end
            c_ST_DONE:  w_next = c_ST_IDLE;
            c_ST_ERROR: w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // Datapath: table index, retry/delay counters, latched entry, status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_retry     <= '0;
            r_count     <= 8'd0;
            r_tick      <= '0;
            r_xfer_data <= 24'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_boot      <= 1'b1;
        end else begin
            // Auto-start window is only the first cycle after reset.
            r_boot <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_next == c_ST_FETCH) begin
                        r_idx       <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                    end
                end
                c_ST_DECODE: begin
                    if (w_is_delay && !w_is_end) begin
                        r_count <= bus.rom_data[7:0];
                        r_tick  <= '0;
                    end else if (!w_is_end) begin
                        r_xfer_data <= bus.rom_data;
                        r_retry     <= '0;
                    end
                end
                c_ST_WAIT: begin
                    if (bus.xfer_done) begin
                        if (!bus.xfer_nack) begin
                            if (!w_last) begin
                                r_idx <= r_idx + TABLE_AW'(1);
                            end
                        end else if (r_retry != c_RETRY_MAX) begin
                            r_retry <= r_retry + c_RETRY_W'(1);
                        end
                    end
                end
                c_ST_DELAY: begin
                    if (w_delay_fin) begin
                        if (!w_last) begin
                            r_idx <= r_idx + TABLE_AW'(1);
                        end
                    end else if (r_tick == c_TICK_LAST) begin
                        r_tick  <= '0;
                        r_count <= r_count - 8'd1;
                    end else begin
                        r_tick <= r_tick + c_TICK_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_done <= 1'b1;
                end
                c_ST_ERROR: begin
                    r_error     <= 1'b1;
                    r_err_index <= r_idx;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.rom_addr   = r_idx;
        bus.xfer_valid = (r_state == c_ST_ISSUE);
        bus.xfer_dev   = DEV_ADDR;
        bus.xfer_data  = r_xfer_data;
        busy           = (r_state != c_ST_IDLE);
        done           = r_done;
        error          = r_error;
        err_index      = r_err_index;
    end
endmodule
`default_nettype wire

// File: tb/tb_codec_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_codec_cfg_sequencer
//  Description : Self-checking bench for codec_cfg_sequencer. A table ROM and
//                an I2C master model drive the DUT; a table-walking reference
//                model predicts the transfer list and final status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_cfg_sequencer;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int TICK  = 10;
    localparam int MAXR  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          start2;
    logic          busy, done, error;
    logic [AW-1:0] err_index;
    logic          busy2, done2, error2;
    logic [AW-1:0] err_index2;

    codec_cfg_sequencer_if #(.TABLE_AW(AW)) bus  ();
    codec_cfg_sequencer_if #(.TABLE_AW(AW)) bus2 ();

    codec_cfg_sequencer #(
        .DEV_ADDR(7'h3B), .TABLE_AW(AW), .TICK_CYCLES(TICK),
        .MAX_RETRY(MAXR), .AUTO_START(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    codec_cfg_sequencer #(
        .DEV_ADDR(7'h3B), .TABLE_AW(AW), .TICK_CYCLES(TICK),
        .MAX_RETRY(MAXR), .AUTO_START(1'b0)
    ) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
        .busy(busy2), .done(done2), .error(error2), .err_index(err_index2)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [DEPTH];
    bit          nack_plan [64];
    int          np_len, np_ptr;
    logic [23:0] obs_q [$];
    int          hs_t [$];
    int          dn_t [$];
    int          cyc = 0;
    bit          hold_ready, always_ready;
    int          lat_min, lat_max;
    logic [23:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_idx;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Table ROM with one cycle of read latency
    always @(posedge clk) begin
        bus.rom_data  <= rom[bus.rom_addr];
        bus2.rom_data <= rom[bus2.rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // I2C master model: all drives on the falling edge
    initial begin : p_master
        int lat;
        bit aborted;
        bus.xfer_ready = 1'b0;
        bus.xfer_done  = 1'b0;
        bus.xfer_nack  = 1'b0;
        forever begin
            @(negedge clk);
            bus.xfer_done = 1'b0;
            bus.xfer_nack = 1'b0;
            if (!rst_n || hold_ready) bus.xfer_ready = 1'b0;
            else bus.xfer_ready = always_ready || ($urandom_range(0, 2) != 0);
            if (rst_n && bus.xfer_valid && bus.xfer_ready) begin
                obs_q.push_back(bus.xfer_data);
                hs_t.push_back(cyc + 1);
                check("xfer_dev", 32'(bus.xfer_dev), 32'h3B);
                lat = $urandom_range(lat_min, lat_max);
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    bus.xfer_ready = 1'b0;
                    if (!rst_n) aborted = 1'b1;
                end
                if (!aborted && rst_n) begin
                    bus.xfer_done = 1'b1;
                    bus.xfer_nack = (np_ptr < np_len) ? nack_plan[np_ptr] : 1'b0;
                    np_ptr++;
                    dn_t.push_back(cyc + 1);
                end
            end
        end
    end

    // Reference: walk the table entry by entry, consuming the NACK plan
    task automatic run_model();
        int          idx;
        int          p;
        bit          fin, ok;
        logic [23:0] e;
        idx = 0; p = 0; fin = 0;
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_idx = 0;
        while (!fin) begin
            e = rom[idx];
            if (e == 24'hFFFFFF) begin
                exp_done = 1; fin = 1;
            end else begin
                if (e[23:8] != 16'hFFFE) begin
                    ok = 0;
                    for (int a = 0; a <= MAXR && !ok; a++) begin
                        exp_q.push_back(e);
                        ok = !((p < np_len) ? nack_plan[p] : 1'b0);
                        p++;
                    end
                    if (!ok) begin exp_err = 1; exp_idx = idx; fin = 1; end
                end
                if (!fin) begin
                    if (idx == DEPTH - 1) begin exp_err = 1; exp_idx = idx; fin = 1; end
                    else idx++;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); hs_t.delete(); dn_t.delete();
        np_ptr = 0;
    endtask

    task automatic fill_end();
        for (int i = 0; i < DEPTH; i++) rom[i] = 24'hFFFFFF;
    endtask

    task automatic pulse_start(input bit chk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (chk) begin
            check("start_busy", 32'(busy), 32'd1);
            check("start_done_clr", 32'(done), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        t = 0;
        while (busy && t < 5000) begin @(negedge clk); t++; end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare_run(input string tag);
        int n;
        run_model();
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        if (exp_err) check({tag, "_err_index"}, 32'(err_index), 32'(exp_idx));
    endtask

    initial begin : p_watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int          n, gap;
        logic [23:0] cap;
        bit          stable;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        hold_ready = 1'b0; always_ready = 1'b1;
        lat_min = 5; lat_max = 5; np_len = 0; np_ptr = 0;
        bus2.xfer_ready = 1'b1; bus2.xfer_done = 1'b0; bus2.xfer_nack = 1'b0;

        // Reset / autostart
        fill_end();
        rom[0] = 24'h400001; rom[1] = 24'h401501;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(bus.xfer_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);
        check("rst_dev", 32'(bus.xfer_dev), 32'h3B);
        check("rst_data", 32'(bus.xfer_data), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst2_status", {29'd0, busy2, done2, error2}, 32'd0);
        check("rst2_err_index", 32'(err_index2), 32'd0);
        rst_n = 1'b1;
        wait_idle();
        compare_run("autostart");

        // AUTO_START=0 instance stays idle until a start pulse
        check("ns_idle_busy", 32'(busy2), 32'd0);
        check("ns_idle_valid", 32'(bus2.xfer_valid), 32'd0);
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (!bus2.xfer_valid && n < 10) begin @(negedge clk); n++; end
        check("ns_start_valid", 32'(bus2.xfer_valid), 32'd1);
        check("ns_start_data", 32'(bus2.xfer_data), 32'h400001);

        // Backpressure: ready held low for 20 cycles
        fill_end(); rom[0] = 24'h401234;
        clear_obs(); np_len = 0; lat_min = 2; lat_max = 2;
        hold_ready = 1'b1;
        pulse_start(1'b1);
        n = 0;
        while (!bus.xfer_valid && n < 10) begin @(negedge clk); n++; end
        cap = bus.xfer_data; stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!bus.xfer_valid || bus.xfer_data != cap) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_data", 32'(cap), 32'h401234);
        check("bp_no_hs", obs_q.size(), 0);
        hold_ready = 1'b0;
        wait_idle();
        compare_run("backpressure");

        // Retry: entry 1 NACKed twice then ACKed; write-to-write overhead
        fill_end();
        rom[0] = 24'h110011; rom[1] = 24'h220022; rom[2] = 24'h330033;
        clear_obs(); lat_min = 3; lat_max = 3;
        np_len = 5;
        nack_plan[0] = 0; nack_plan[1] = 1; nack_plan[2] = 1; nack_plan[3] = 0; nack_plan[4] = 0;
        pulse_start(1'b1);
        wait_idle();
        compare_run("retry_ok");
        if (hs_t.size() >= 3 && dn_t.size() >= 2) begin
            check("gap_next_entry", hs_t[1] - dn_t[0], 3);
            check("gap_retry", hs_t[2] - dn_t[1], 1);
        end else check("gap_samples", hs_t.size(), 3);

        // Retry exhausted on entry 1
        clear_obs();
        nack_plan[0] = 0; nack_plan[1] = 1; nack_plan[2] = 1; nack_plan[3] = 1; nack_plan[4] = 1;
        pulse_start(1'b1);
        wait_idle();
        repeat (20) @(negedge clk);
        compare_run("retry_fail");

        // Delay entries: 3 ms and 0 ms
        fill_end();
        rom[0] = 24'h400001; rom[1] = 24'hFFFE03; rom[2] = 24'h400102;
        rom[3] = 24'hFFFE00; rom[4] = 24'h400203;
        clear_obs(); np_len = 0; lat_min = 2; lat_max = 2;
        pulse_start(1'b1);
        wait_idle();
        compare_run("delay");
        if (hs_t.size() >= 3 && dn_t.size() >= 2) begin
            gap = hs_t[1] - dn_t[0];
            check("delay3_gap", 32'(gap >= 5 + 3 * TICK - 1 && gap <= 5 + 3 * TICK + 1), 32'd1);
            gap = hs_t[2] - dn_t[1];
            check("delay0_gap", 32'(gap >= 5 && gap <= 7), 32'd1);
        end else check("delay_samples", hs_t.size(), 3);

        // Table overrun: no END marker anywhere
        for (int i = 0; i < DEPTH; i++) rom[i] = {16'h1000 + 16'(i), 8'(i)};
        clear_obs(); np_len = 0; lat_min = 1; lat_max = 1;
        pulse_start(1'b1);
        wait_idle();
        compare_run("overrun");

        // Reset mid-transaction
        fill_end(); rom[0] = 24'h4A00AA; rom[1] = 24'h4B00BB;
        clear_obs(); np_len = 0; lat_min = 6; lat_max = 6;
        pulse_start(1'b1);
        n = 0;
        while (obs_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.xfer_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(bus.xfer_data), 32'd0);
        check("mid_rst_status", {30'd0, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        clear_obs();
        rst_n = 1'b1;
        wait_idle();
        compare_run("after_rst");
        check("ns_no_autostart", 32'(busy2), 32'd0);

        // Randomized tables, NACKs, backpressure, ignored start pulses
        always_ready = 1'b0; lat_min = 1; lat_max = 6;
        for (int it = 0; it < 8; it++) begin
            fill_end();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) < 7)
                    rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom_range(0, 255))};
                else
                    rom[i] = {16'hFFFE, 8'($urandom_range(0, 2))};
            end
            np_len = 32;
            for (int i = 0; i < 32; i++) nack_plan[i] = ($urandom_range(0, 3) == 0);
            clear_obs();
            pulse_start(1'b1);
            repeat (6) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
            compare_run("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
